// File: rtl/display_writer.sv
// display_writer: converts a 27-bit binary value to eight decimal digits with a
// serial shift-add-3 (double dabble) pass, then writes the digits to a display
// controller from the leftmost position down to the rightmost, with leading-zero
// blanking. Values above 99_999_999 skip the conversion and show eight dashes.
module display_writer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [26:0] value,
    output logic [3:0]  dig,
    output logic [3:0]  pos,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [26:0] OVF_LIMIT  = 27'd99_999_999;
    localparam logic [4:0]  LAST_ITER  = 5'd26;
    localparam logic [3:0]  CODE_DASH  = 4'hE;
    localparam logic [3:0]  CODE_BLANK = 4'hF;
    localparam logic [3:0]  POS_NONE   = 4'hF;
    localparam logic [3:0]  POS_LEFT   = 4'd7;

    state_t      state_q, state_d;
    logic [26:0] shift_q, shift_d;
    logic [31:0] bcd_q,   bcd_d;
    logic [4:0]  iter_q,  iter_d;
    logic        ovf_q,   ovf_d;
    logic [3:0]  dig_q,   dig_d;
    logic [3:0]  pos_q,   pos_d;
    logic        busy_q,  busy_d;
    logic        done_q,  done_d;
    logic [58:0] step_s;

    // One double-dabble iteration: correct every BCD digit >= 5 by adding 3,
    // then shift the combined {bcd, binary} register left by one bit.
    function automatic logic [58:0] dabble_step(input logic [31:0] bcd_in,
                                                input logic [26:0] bin_in);
        logic [31:0] adj;
        adj = bcd_in;
        for (int i = 0; i < 8; i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = adj[4*i +: 4];
            end
        end
        return {adj[30:0], bin_in[26], bin_in[25:0], 1'b0};
    endfunction

    // Display code for one position: the BCD numeral, or blank when this
    // position and everything to its left is zero (position 0 never blanks).
    function automatic logic [3:0] digit_code(input logic [31:0] bcd_in,
                                              input logic [2:0]  p);
        logic       all_zero_left;
        logic [3:0] code;
        all_zero_left = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if ((i >= int'(p)) && (bcd_in[4*i +: 4] != 4'd0)) begin
                all_zero_left = 1'b0;
            end else begin
                all_zero_left = all_zero_left;
            end
        end
        if ((p != 3'd0) && all_zero_left) begin
            code = CODE_BLANK;
        end else begin
            code = bcd_in[{p, 2'b00} +: 4];
        end
        return code;
    endfunction

    assign step_s = dabble_step(bcd_q, shift_q);

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= 27'd0;
            bcd_q   <= 32'd0;
            iter_q  <= 5'd0;
            ovf_q   <= 1'b0;
            dig_q   <= CODE_BLANK;
            pos_q   <= POS_NONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
            iter_q  <= iter_d;
            ovf_q   <= ovf_d;
            dig_q   <= dig_d;
            pos_q   <= pos_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath update: capture, convert, walk positions, finish.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        iter_d  = iter_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = value;
                    bcd_d   = 32'd0;
                    iter_d  = 5'd0;
                    if (value > OVF_LIMIT) begin
                        ovf_d   = 1'b1;
                        state_d = EMIT;
                    end else begin
                        ovf_d   = 1'b0;
                        state_d = CONV;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                bcd_d   = step_s[58:27];
                shift_d = step_s[26:0];
                iter_d  = iter_q + 5'd1;
                if (iter_q == LAST_ITER) begin
                    state_d = EMIT;
                end else begin
                    state_d = CONV;
                end
            end
            EMIT: begin
                if (pos_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    state_d = EMIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output next values, derived from the upcoming state so every output
    // comes straight from a flop and lines up with its state's cycle.
    always_comb begin
        dig_d  = CODE_BLANK;
        pos_d  = POS_NONE;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            IDLE: begin
                busy_d = 1'b0;
            end
            CONV: begin
                busy_d = 1'b1;
            end
            EMIT: begin
                busy_d = 1'b1;
                if (state_q == EMIT) begin
                    pos_d = pos_q - 4'd1;
                end else begin
                    pos_d = POS_LEFT;
                end
                if (ovf_d) begin
                    dig_d = CODE_DASH;
                end else begin
                    dig_d = digit_code(bcd_d, pos_d[2:0]);
                end
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign dig  = dig_q;
    assign pos  = pos_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_display_writer.sv
// Self-checking bench for display_writer. The reference model computes the
// expected {busy, done, pos, dig} of every cycle after a request from decimal
// arithmetic on the requested value.
module tb_display_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [26:0] value = 27'd0;
    logic [3:0]  dig;
    logic [3:0]  pos;
    logic        busy;
    logic        done;

    int total = 0;
    int bad   = 0;

    localparam logic [9:0] IDLE_OUT = {1'b0, 1'b0, 4'hF, 4'hF};

    display_writer dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .value (value),
        .dig   (dig),
        .pos   (pos),
        .busy  (busy),
        .done  (done)
    );

    always #5 clock = ~clock;

    // Expected {busy, done, pos, dig} k cycles after the start cycle N.
    function automatic logic [9:0] exp_out(input longint v, input int k);
        longint d [8];
        longint rem;
        int     msd;
        int     p;
        logic [3:0] code;
        if (v > 64'd99_999_999) begin
            if (k >= 1 && k <= 8) return {1'b1, 1'b0, 4'(8 - k), 4'hE};
            if (k == 9) return {1'b0, 1'b1, 4'hF, 4'hF};
            return IDLE_OUT;
        end
        rem = v;
        msd = 0;
        for (int i = 0; i < 8; i++) begin
            d[i] = rem % 10;
            rem  = rem / 10;
            if (d[i] != 0) msd = i;
        end
        if (k >= 1 && k <= 27) return {1'b1, 1'b0, 4'hF, 4'hF};
        if (k >= 28 && k <= 35) begin
            p = 35 - k;
            code = (p > msd) ? 4'hF : 4'(d[p]);
            return {1'b1, 1'b0, 4'(p), code};
        end
        if (k == 36) return {1'b0, 1'b1, 4'hF, 4'hF};
        return IDLE_OUT;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        value = 27'd12345;
        repeat (3) @(negedge clock);
        total++;
        if ({busy, done, pos, dig} !== IDLE_OUT) begin
            bad++;
            $display("FAIL reset_hold actual=%h required=%h", {busy, done, pos, dig}, IDLE_OUT);
        end
        reset = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clock);
        total++;
        if ({busy, done, pos, dig} !== IDLE_OUT) begin
            bad++;
            $display("FAIL reset_idle actual=%h required=%h", {busy, done, pos, dig}, IDLE_OUT);
        end
    endtask

    task automatic test_known();
        longint vals [3] = '{64'd12345, 64'd0, 64'd10203};
        int ndone;
        foreach (vals[j]) begin
            start = 1'b1;
            value = 27'(vals[j]);
            @(negedge clock);
            start = 1'b0;
            ndone = 0;
            for (int k = 1; k <= 37; k++) begin
                if (done === 1'b1) ndone++;
                total++;
                if ({busy, done, pos, dig} !== exp_out(vals[j], k)) begin
                    bad++;
                    $display("FAIL known v=%0d k=%0d actual=%h required=%h",
                             vals[j], k, {busy, done, pos, dig}, exp_out(vals[j], k));
                end
                @(negedge clock);
            end
            total++;
            if (ndone !== 1) begin
                bad++;
                $display("FAIL known_done_count v=%0d actual=%0d required=1", vals[j], ndone);
            end
        end
    endtask

    task automatic test_boundary();
        longint vals [5] = '{64'd99_999_999, 64'd100_000_000, 64'h7FF_FFFF,
                             64'd10_000_000, 64'd1};
        foreach (vals[j]) begin
            start = 1'b1;
            value = 27'(vals[j]);
            @(negedge clock);
            start = 1'b0;
            for (int k = 1; k <= 37; k++) begin
                total++;
                if ({busy, done, pos, dig} !== exp_out(vals[j], k)) begin
                    bad++;
                    $display("FAIL boundary v=%0d k=%0d actual=%h required=%h",
                             vals[j], k, {busy, done, pos, dig}, exp_out(vals[j], k));
                end
                @(negedge clock);
            end
        end
    endtask

    task automatic test_random();
        longint v;
        for (int j = 0; j < 16; j++) begin
            if (j % 4 == 3) v = longint'($urandom_range(27'h7FF_FFFF, 0));
            else if (j % 4 == 2) v = longint'($urandom_range(999, 0));
            else v = longint'($urandom_range(99_999_999, 0));
            start = 1'b1;
            value = 27'(v);
            @(negedge clock);
            start = 1'b0;
            for (int k = 1; k <= 37; k++) begin
                total++;
                if ({busy, done, pos, dig} !== exp_out(v, k)) begin
                    bad++;
                    $display("FAIL random v=%0d k=%0d actual=%h required=%h",
                             v, k, {busy, done, pos, dig}, exp_out(v, k));
                end
                @(negedge clock);
            end
        end
    endtask

    task automatic test_ignore_start();
        int writes;
        start = 1'b1;
        value = 27'd42;
        @(negedge clock);
        start = 1'b0;
        writes = 0;
        for (int k = 1; k <= 37; k++) begin
            if (pos !== 4'hF) writes++;
            total++;
            if ({busy, done, pos, dig} !== exp_out(42, k)) begin
                bad++;
                $display("FAIL ignore v=42 k=%0d actual=%h required=%h",
                         k, {busy, done, pos, dig}, exp_out(42, k));
            end
            start = (k == 5 || k == 30 || k == 37) ? 1'b1 : 1'b0;
            value = (k == 37) ? 27'd7 : 27'd99_999;
            @(negedge clock);
        end
        start = 1'b0;
        total++;
        if (writes !== 8) begin
            bad++;
            $display("FAIL ignore_write_count actual=%0d required=8", writes);
        end
        for (int k = 1; k <= 37; k++) begin
            total++;
            if ({busy, done, pos, dig} !== exp_out(7, k)) begin
                bad++;
                $display("FAIL ignore_next v=7 k=%0d actual=%h required=%h",
                         k, {busy, done, pos, dig}, exp_out(7, k));
            end
            @(negedge clock);
        end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        value = 27'd87_654_321;
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            total++;
            if ({busy, done, pos, dig} !== exp_out(87_654_321, k)) begin
                bad++;
                $display("FAIL reset_mid_pre k=%0d actual=%h required=%h",
                         k, {busy, done, pos, dig}, exp_out(87_654_321, k));
            end
            @(negedge clock);
            if (k == 29) reset = 1'b1;
        end
        reset = 1'b0;
        for (int k = 31; k <= 45; k++) begin
            total++;
            if ({busy, done, pos, dig} !== IDLE_OUT) begin
                bad++;
                $display("FAIL reset_mid_after k=%0d actual=%h required=%h",
                         k, {busy, done, pos, dig}, IDLE_OUT);
            end
            @(negedge clock);
        end
        start = 1'b1;
        value = 27'd5;
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= 37; k++) begin
            total++;
            if ({busy, done, pos, dig} !== exp_out(5, k)) begin
                bad++;
                $display("FAIL reset_mid_next v=5 k=%0d actual=%h required=%h",
                         k, {busy, done, pos, dig}, exp_out(5, k));
            end
            @(negedge clock);
        end
    endtask

    task automatic test_back_to_back();
        longint vals [4];
        foreach (vals[j]) vals[j] = longint'($urandom_range(99_999_999, 0));
        start = 1'b1;
        value = 27'(vals[0]);
        @(negedge clock);
        for (int r = 0; r < 4; r++) begin
            for (int k = 1; k <= 37; k++) begin
                total++;
                if ({busy, done, pos, dig} !== exp_out(vals[r], k)) begin
                    bad++;
                    $display("FAIL back_to_back r=%0d v=%0d k=%0d actual=%h required=%h",
                             r, vals[r], k, {busy, done, pos, dig}, exp_out(vals[r], k));
                end
                if (k == 37) begin
                    if (r < 3) value = 27'(vals[r + 1]);
                    else start = 1'b0;
                end
                @(negedge clock);
            end
        end
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_known();
        test_boundary();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_writer.md
DISPLAY_WRITER -- requirements
Module: display_writer

Interface
REQ-001 Ports SHALL be, clock and reset first:
- clock  in  1  single system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request to display value; sampled only in IDLE
- value  in  27  unsigned binary number to display
- dig  out  4  digit code to the display controller: 0-9 numeral, 4'hE dash, 4'hF blank
- pos  out  4  display position being written, 0 = rightmost, 7 = leftmost; 4'hF = no write this cycle
- busy  out  1  high from the cycle after start is accepted until done is asserted
- done  out  1  one-cycle pulse when the last write has been issued

REQ-002 The block SHALL have one clock domain, with reset synchronous and active-high, named clock and reset.

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, CONV, EMIT and DONE.

REQ-004 In IDLE with start=1 at cycle N, the block SHALL capture value and set busy=1 from N+1.

REQ-005 The block SHALL ignore start in every state other than IDLE; no capture or restart occurs.

REQ-006 Overflow: if the captured value is greater than 99_999_999, the block SHALL skip CONV, enter EMIT at N+1 and write dig=4'hE to all eight positions.

REQ-007 Otherwise the block SHALL enter CONV.
- It performs a 27-iteration shift-add-3 binary-to-BCD conversion, one iteration per cycle (N+1..N+27).
- The result is 8 BCD digits.

REQ-008 EMIT SHALL last exactly 8 cycles.
- pos takes 7,6,5,4,3,2,1,0, one position per cycle.
- dig holds the code for that position in the same cycle.
- Non-overflow timing: EMIT occupies N+28..N+35.

REQ-009 Leading-zero blanking SHALL apply: every position above the most significant nonzero digit is written with dig=4'hF.
- Position 0 always shows its numeral.
- Value 0 therefore displays a single "0".

REQ-010 Interior and trailing zeros SHALL be written as numeral 0, not blank.

REQ-011 DONE SHALL last one cycle, with done=1, busy=0 and pos=4'hF, then return to IDLE.
- Non-overflow: done at N+36.
- Overflow: done at N+9.

REQ-012 A new start SHALL be accepted in the IDLE cycle that immediately follows DONE (N+37 at the earliest).

REQ-013 In IDLE, CONV and DONE, pos SHALL be 4'hF and dig SHALL be 4'hF; the downstream controller must never see a write outside EMIT.

REQ-014 Every output SHALL be registered, with no combinational path from any input to any output.

REQ-015 Each EMIT cycle SHALL issue exactly one write; no position is skipped or repeated.

Reset
REQ-016 With reset=1 at a clock edge, the block SHALL set:
- state to IDLE
- busy=0 and done=0
- pos=4'hF and dig=4'hF
- the BCD/shift registers to 0

REQ-017 Reset SHALL take priority over start and over any in-progress conversion or emission.
- A reset asserted mid-CONV or mid-EMIT stops all further writes from the next cycle.
- No done pulse is produced for the aborted request.

REQ-018 After reset is released, the first start SHALL be accepted normally as in REQ-004.

Verification
REQ-019 Start with value=12345 at N, and check:
- Writes at N+28..N+35 are (7,F)(6,F)(5,F)(4,1)(3,2)(2,3)(1,4)(0,5).
- done=1 only at N+36.
- busy=1 over N+1..N+35.

REQ-020 Value 0 SHALL produce (7..1,F) followed by (0,0); value 10203 SHALL produce (7..5,F)(4,1)(3,0)(2,2)(1,0)(0,3).

REQ-021 Value 99_999_999 SHALL write dig 9 to all eight positions; value 100_000_000 SHALL write (7..0,E) at N+1..N+8, with done at N+9.

REQ-022 Start pulsed again at N+5 and N+30 during a conversion of 42 SHALL be ignored.
- Exactly 8 writes occur.
- The second request is accepted only when start is asserted at N+37 or later.

REQ-023 Reset asserted at N+30 during an EMIT of 87654321 SHALL give:
- pos=4'hF from N+31 onward
- no done pulse
- busy=0
- A following start of 5 then completes correctly.

REQ-024 Back-to-back requests (start held high continuously) SHALL give:
- one accepted request every 37 cycles
- pos never showing a value other than 4'hF outside EMIT cycles
